// File: rtl/input_debouncer.sv
// ---------------------------------------------------------------------------
// input_debouncer
//
// Cleans raw, asynchronous, bouncy inputs (buttons/switches) so they can drive
// gate inputs directly. Each channel is fully independent: a 2-flop
// synchroniser followed by a counter-based debounce FSM. A new level is only
// accepted after it has been seen on the synchronised input for STABLE_CYCLES
// consecutive cycles; any reversal in between restarts the qualification.
//
// Parameters
//   WIDTH          number of independent input channels
//   STABLE_CYCLES  consecutive synchronised cycles a new level must hold (>=1)
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset (clears everything)
//   in_raw     in   WIDTH  raw asynchronous inputs
//   out_clean  out  WIDTH  debounced, registered levels
//   rise       out  WIDTH  1-cycle pulse when out_clean goes 0->1
//   fall       out  WIDTH  1-cycle pulse when out_clean goes 1->0
//
// Latency: with a clean input change first sampled at edge E0, out_clean and
// the matching rise/fall pulse update at edge E(STABLE_CYCLES+1).
//
// Per-channel FSM state is held in the enum array 'state' and the counter
// array 'cnt', both readable hierarchically for debug.
// ---------------------------------------------------------------------------
module input_debouncer #(
    parameter int WIDTH         = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_raw,
    output logic [WIDTH-1:0] out_clean,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    // Counter is wide enough to hold STABLE_CYCLES; it never wraps because
    // the FSM leaves CHECKING once it reaches STABLE_CYCLES-1.
    localparam int              CW   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]   LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic {
        STABLE   = 1'b0,
        CHECKING = 1'b1
    } state_t;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    state_t           state [WIDTH];
    logic [CW-1:0]    cnt   [WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            out_clean <= '0;
            rise      <= '0;
            fall      <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                state[i] <= STABLE;
                cnt[i]   <= '0;
            end
        end else begin
            sync1 <= in_raw;
            sync2 <= sync1;

            for (int i = 0; i < WIDTH; i++) begin
                // Pulses are single-cycle: cleared unless set below.
                rise[i] <= 1'b0;
                fall[i] <= 1'b0;

                case (state[i])
                    STABLE: begin
                        if (sync2[i] != out_clean[i]) begin
                            if (STABLE_CYCLES == 1) begin
                                // One qualifying sample is enough: accept now.
                                out_clean[i] <= sync2[i];
                                rise[i]      <= sync2[i];
                                fall[i]      <= ~sync2[i];
                            end else begin
                                // This sample is the first of the run.
                                state[i] <= CHECKING;
                                cnt[i]   <= CW'(1);
                            end
                        end
                    end

                    CHECKING: begin
                        if (sync2[i] == out_clean[i]) begin
                            // Bounce back to the current level: drop the run.
                            state[i] <= STABLE;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == LAST) begin
                            out_clean[i] <= sync2[i];
                            rise[i]      <= sync2[i];
                            fall[i]      <= ~sync2[i];
                            state[i]     <= STABLE;
                            cnt[i]       <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + CW'(1);
                        end
                    end

                    default: begin
                        state[i] <= STABLE;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
